shift_add_mult: RTL and testbench
=================================

// Module: shift_add_mult
// PURPOSE
//  Sequential unsigned multiplier that time-shares one 5-bit ripple adder (my_sum).
//  An FSM runs one add-and-shift step per clock: start/busy/done handshake in,
//  2N-bit product out. Sits between the lab I/O (switches/buttons) and the display path.
// PARAMETERS
//  N        5   operand width; must equal my_sum width (5); product width is 2N
//  CNT_W    3   iteration counter width; ceil(log2(N+1))
// PORTS
//  clk      in   1    single clock, rising edge
//  rst      in   1    asynchronous, active-high reset
//  start    in   1    request; sampled only in IDLE
//  a        in   N    multiplicand, captured on accepted start
//  b        in   N    multiplier, captured on accepted start
//  busy     out  1    high in CALC and DONE
//  done     out  1    one-cycle pulse; product valid from this cycle
//  product  out  2N   a*b, held until next accepted start
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; M, ACC, Q, cnt, product = 0; busy=0, done=0.
//  - Registers: M[N-1:0] multiplicand, ACC[N-1:0] upper half, Q[N-1:0] lower half, cnt.
//  - Adder hookup: my_sum Ain=ACC, Bin=M, Ci=0 -> Sout, Co. Adder is never used for anything else.
//  - IDLE: busy=0. If start=1: M<=a, Q<=b, ACC<=0, cnt<=0, go CALC. Else hold all.
//  - CALC (N cycles): if Q[0]=1: {ACC,Q} <= {Co, Sout, Q} >> 1
//      else {ACC,Q} <= {1'b0, ACC, Q} >> 1. cnt<=cnt+1.
//      When cnt==N-1 in this cycle -> DONE.
//  - DONE (1 cycle): done=1, busy=1, product<={ACC,Q}, go IDLE.
//      Register product on entry to DONE, so done and the new product are visible together.
//  - Latency: start accepted at edge k. done=1 during cycle k+N+1 (6 cycles for N=5).
//      A new start is accepted from cycle k+N+2.
//  - start while busy (CALC or DONE) is ignored. It is not queued.
//      a and b may change freely after acceptance.
//  - Width rule: carry-out Co becomes the MSB of the shifted ACC. No overflow is possible.
//      Max 31*31=961 fits in 10 bits.
//  - Zero operands need no special case: N cycles still run and product=0.
//  - rst asserted mid-CALC aborts at once. The previous product is cleared to 0.
//      After rst drops, the block waits in IDLE.
//  - done is a registered output, with no combinational path from start.
// STRUCTURE
//  - Shared package/include: state encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2.
//      Also constants N=5 and CNT_W=3.
//  - Single sub-module: my_sum (existing 5-bit adder, ports Ain,Bin,Ci,Sout,Co).
//      No new sub-modules. FSM and shift datapath live in this file.
//  - Unused state 2'd3 decodes to IDLE.
// TESTING
//  1 a=31,b=31,start pulse -> busy 1 for 6 cycles, done at cycle 6, product=10'd961 (0x3C1)
//  2 a=21,b=13 -> product=273. a=0,b=17 -> product=0. a=1,b=1 -> product=1.
//      Latency is 6 in all cases.
//  3 start held high for 10 cycles, with a,b changed at cycle 2 (a=3,b=5, then a=7,b=7)
//      -> only first accepted. product=15, done once, next op starts in cycle 7.
//  4 rst pulsed at cycle 3 of a 9*9 op -> busy=0, done=0, product=0 immediately.
//      No done afterwards. A fresh 9*9 then gives 81.
//  5 back-to-back: 4*6 then 25*30 with start reasserted the cycle after done
//      -> products 24 then 750. done pulses 7 cycles apart.
//  6 exhaustive 0..31 x 0..31 against a reference model.
//      product must match a*b and done must be exactly one cycle wide every time.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: shared constants and FSM state encoding for the shift-add multiplier
package shift_add_mult_pkg;
    localparam int N     = 5;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/my_sum.sv
// my_sum: 5-bit ripple-carry adder
//   Ain, Bin : addends        Ci : carry in
//   Sout     : 5-bit sum      Co : carry out
module my_sum (
    input  logic [4:0] Ain,
    input  logic [4:0] Bin,
    input  logic       Ci,
    output logic [4:0] Sout,
    output logic       Co
);
    logic [5:0] c;
    assign c[0] = Ci;
    for (genvar i = 0; i < 5; i++) begin : g_fa
        assign Sout[i]  = Ain[i] ^ Bin[i] ^ c[i];
        assign c[i + 1] = (Ain[i] & Bin[i]) | (c[i] & (Ain[i] ^ Bin[i]));
    end
    assign Co = c[5];
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned multiplier, one add-and-shift step per clock
//   clk, rst (async, active-high)
//   start    : request, sampled only in IDLE
//   a, b     : multiplicand / multiplier, captured on accepted start
//   busy     : high in CALC and DONE
//   done     : one-cycle pulse, product valid from this cycle
//   product  : a*b, held until the next accepted start
module shift_add_mult
    import shift_add_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);
    state_t state, next_state;
    logic [N-1:0]     m, acc, q, sum;
    logic [CNT_W-1:0] cnt;
    logic             co, last, accept;
    logic [2*N-1:0]   shifted;

    my_sum u_sum (.Ain(acc), .Bin(m), .Ci(1'b0), .Sout(sum), .Co(co));

    // Carry-out becomes the MSB of the shifted accumulator, so nothing is lost.
    assign shifted = q[0] ? {co, sum, q[N-1:1]} : {1'b0, acc, q[N-1:1]};
    assign last    = cnt == CNT_W'(N - 1);
    assign accept  = state == IDLE && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // The unused encoding falls through to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = start ? CALC : IDLE;
            CALC:    next_state = last ? DONE : CALC;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = state == CALC || state == DONE;
        done = state == DONE;
    end

    // Product is loaded on the edge that enters DONE so it appears with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m   <= a;
            q   <= b;
            acc <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            {acc, q} <= shifted;
            cnt      <= cnt + 1'b1;
            if (last) product <= shifted;
        end
    end
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: self-checking bench with vector table and product scoreboard
module tb_shift_add_mult;
    logic       clk = 0, rst = 1, start = 0;
    logic [4:0] a = 0, b = 0;
    logic       busy, done;
    logic [9:0] product;

    int errors = 0, checks = 0, cyc = 0, done_count = 0, width = 0;
    logic [9:0] sb[$];

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] exp;
    } vec_t;
    vec_t vecs[8];

    shift_add_mult dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            width++;
            if (width == 1) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got product %0d expected no done (cycle %0d)", product, cyc);
                end else begin
                    check("product", product, sb.pop_front());
                end
            end
        end else if (width != 0) begin
            check("done_width", width, 1);
            width = 0;
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) check("idle_timeout", g, 0);
    endtask

    task automatic run_op(input logic [4:0] av, input logic [4:0] bv, input logic [9:0] exp, output int done_cyc);
        int lat = 0;
        wait_idle();
        a = av; b = bv; start = 1;
        sb.push_back(exp);
        @(posedge clk); #1;
        start = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 5);
        done_cyc = cyc;
    endtask

    initial begin
        int dc, c1, c2, busy_cnt, done_at;
        vecs[0] = '{5'd31, 5'd31, 10'd961};
        vecs[1] = '{5'd21, 5'd13, 10'd273};
        vecs[2] = '{5'd0,  5'd17, 10'd0};
        vecs[3] = '{5'd1,  5'd1,  10'd1};
        vecs[4] = '{5'd4,  5'd6,  10'd24};
        vecs[5] = '{5'd25, 5'd30, 10'd750};
        vecs[6] = '{5'd31, 5'd0,  10'd0};
        vecs[7] = '{5'd17, 5'd29, 10'd493};

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // 31*31: busy for 6 cycles, done on the 6th
        a = 31; b = 31; start = 1;
        sb.push_back(10'd961);
        @(posedge clk); #1;
        start = 0;
        busy_cnt = 0; done_at = 0;
        for (int i = 1; i <= 8; i++) begin
            busy_cnt += busy;
            if (done && done_at == 0) done_at = i;
            @(posedge clk); #1;
        end
        check("busy_cycles", busy_cnt, 6);
        check("done_cycle", done_at, 6);
        check("held_product", product, 961);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, c1);

        // start held for 10 cycles, operands changed mid-operation
        wait_idle();
        dc = done_count;
        a = 3; b = 5; start = 1;
        sb.push_back(10'd15);
        sb.push_back(10'd49);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin a = 7; b = 7; end
            if (i == 6) begin
                check("held_start_idle_gap", busy, 0);
                check("held_start_one_done", done_count - dc, 1);
            end
            if (i == 7) check("held_start_reaccept", busy, 1);
        end
        start = 0;
        for (int g = 0; g < 10 && done_count - dc < 2; g++) begin
            @(posedge clk); #1;
        end
        check("held_start_dones", done_count - dc, 2);

        // reset in the middle of a 9*9
        wait_idle();
        a = 9; b = 9; start = 1;
        sb.push_back(10'd81);
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 1);
        rst = 1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_product", product, 0);
        sb.delete();
        dc = done_count;
        @(posedge clk); #1;
        rst = 0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("post_rst_no_done", done_count - dc, 0);
        check("post_rst_busy", busy, 0);
        run_op(9, 9, 10'd81, c1);

        // back-to-back
        run_op(4, 6, 10'd24, c1);
        run_op(25, 30, 10'd750, c2);
        check("b2b_spacing", c2 - c1, 7);

        // exhaustive against a*b
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                run_op(5'(x), 5'(y), 10'(x * y), c1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
